// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter steering a shared data path.
// Define ARB_TIMEOUT_EN to limit a contended grant to HOLD_MAX cycles.
module mux_arbiter #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              select,
  output logic [DATA_W-1:0] out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, nxt;
  logic last_served;
  logic expire;
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("HOLD_MAX must be in 2..255");
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign expire = hold_cnt == 8'(HOLD_MAX - 1);
  // Counter saturates at the limit so an uncontended grant can run indefinitely.
  always_ff @(posedge clk)
    if (!rst_n || nxt != state) hold_cnt <= '0;
    else if (state != IDLE && !expire) hold_cnt <= hold_cnt + 8'd1;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req0 && req1 ? (last_served ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
      GRANT0:  nxt = req0 && !(expire && req1) ? GRANT0 : req1 ? GRANT1 : IDLE;
      GRANT1:  nxt = req1 && !(expire && req0) ? GRANT1 : req0 ? GRANT0 : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      select      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state <= nxt;
      if (nxt != IDLE) begin
        select      <= nxt == GRANT1;
        last_served <= nxt == GRANT1;
      end
    end
  assign gnt0 = state == GRANT0;
  assign gnt1 = state == GRANT1;
  assign busy = gnt0 || gnt1;
  assign out  = gnt1 ? d1 : gnt0 ? d0 : '0;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random stimulus checked against a behavioural arbiter model.
module tb_mux_arbiter;
  localparam int DW = 8;
  localparam int HM = 4;
  logic clk = 1'b0;
  logic rst_n, req0, req1, gnt0, gnt1, select, busy;
  logic [DW-1:0] d0, d1, out;
  int checks = 0;
  int errors = 0;
  int owner = -1;
  int last  = 1;
  int sel   = 0;
  int held  = 0;

  mux_arbiter #(.DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .select(select), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // owner: -1 idle, else index holding the path; held counts cycles of the current grant.
  task automatic model_step();
    int nxt;
    bit mine, other, expire;
    if (!rst_n) begin
      owner = -1; last = 1; sel = 0; held = 0;
      return;
    end
    nxt = owner;
    if (owner < 0) begin
      if (req0 && req1) nxt = 1 - last;
      else if (req0) nxt = 0;
      else if (req1) nxt = 1;
    end else begin
      mine   = owner == 0 ? req0 : req1;
      other  = owner == 0 ? req1 : req0;
      expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
      expire = other && held >= HM;
`endif
      if (!mine || expire) nxt = other ? 1 - owner : -1;
    end
    if (nxt >= 0 && nxt != owner) begin
      held = 1; last = nxt; sel = nxt;
    end else if (nxt >= 0) held++;
    owner = nxt;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] eo;
    eo = owner == 1 ? d1 : owner == 0 ? d0 : '0;
    chk("gnt0", 32'(gnt0), 32'(owner == 0));
    chk("gnt1", 32'(gnt1), 32'(owner == 1));
    chk("exclusive", 32'(gnt0 & gnt1), 32'd0);
    chk("select", 32'(select), 32'(sel));
    chk("busy", 32'(busy), 32'(gnt0 | gnt1));
    chk("out", 32'(out), 32'(eo));
  endtask

  task automatic cyc(input logic rn, input logic r0, input logic r1);
    rst_n = rn; req0 = r0; req1 = r1;
    d0 = DW'($urandom); d1 = DW'($urandom);
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    d0 = DW'($urandom); d1 = DW'($urandom);
    #1;
    chk("out_comb", 32'(out), 32'(owner == 1 ? d1 : owner == 0 ? d0 : '0));
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("reset_gnt0", 32'(gnt0), 32'd0);
    chk("reset_select", 32'(select), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    repeat (3) cyc(1, 1, 0);
    chk("single_gnt0", 32'(gnt0), 32'd1);
    cyc(1, 0, 0);
    chk("release_idle", 32'(busy), 32'd0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    chk("first_tie_gnt0", 32'(gnt0), 32'd1);
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    chk("handoff_gnt1", 32'(gnt1), 32'd1);
    chk("handoff_select", 32'(select), 32'd1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1);
      chk("alternate", 32'(gnt1), 32'(i % 2));
      cyc(1, 0, 0);
    end
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    chk("reset_mid_gnt1", 32'(gnt1), 32'd0);
    chk("reset_mid_select", 32'(select), 32'd0);
    cyc(1, 0, 1);
    chk("regrant_gnt1", 32'(gnt1), 32'd1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (6) cyc(1, 1, 1);
    repeat (8) cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
